accel_tilt_filter: RTL

//  Conditions raw accelerometer tilt samples into the 10-bit two's-complement

---
 rtl/accel_filter_pkg.sv | 20 ++
 rtl/accel_tilt_filter_if.sv | 22 ++
 rtl/accel_tilt_filter_slew_limiter.sv | 52 +++++
 rtl/accel_tilt_filter.sv | 109 ++++++++++
 4 files changed

// File: rtl/accel_filter_pkg.sv
// Shared types, limits and helpers for the accelerometer tilt conditioning path.
package accel_filter_pkg;

  localparam int unsigned PWM_W   = 10;
  localparam int          PWM_MAX = 511;
  localparam int          PWM_MIN = -511;

  typedef logic signed [PWM_W-1:0] pwm_set_t;

  // Clamp a signed value into the symmetric PWM range; -512 is never produced.
  function automatic pwm_set_t sat_pwm(input logic signed [31:0] x);
    if (x > 32'(PWM_MAX)) begin
      return PWM_W'(PWM_MAX);
    end else if (x < 32'(PWM_MIN)) begin
      return PWM_W'(PWM_MIN);
    end
    return PWM_W'(x);
  endfunction

endpackage

// File: rtl/accel_tilt_filter_if.sv
// Sample-in / filtered-setting-out bus between the sensor front end and the PWM drive.
interface accel_tilt_filter_if
  import accel_filter_pkg::*;
#(
  parameter int unsigned DATA_W = 12
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_data;
  logic                     filt_valid;
  pwm_set_t                 filt_data;
  logic                     filt_primed;

  modport master (
    output sample_valid, sample_data,
    input  filt_valid, filt_data, filt_primed
  );

  modport slave (
    input  sample_valid, sample_data,
    output filt_valid, filt_data, filt_primed
  );
endinterface

// File: rtl/accel_tilt_filter_slew_limiter.sv
// Output stage: moves the held drive setting toward the target by at most MAX_STEP per strobe.
module slew_limiter
  import accel_filter_pkg::*;
#(
  parameter int unsigned MAX_STEP = 16
) (
  input  logic     CLOCK_50,
  input  logic     reset,
  input  logic     in_valid,
  input  pwm_set_t target,
  output logic     out_valid,
  output pwm_set_t out_data
);

  localparam int unsigned DIFF_W = PWM_W + 1;
  localparam logic signed [DIFF_W-1:0] STEP_POS = DIFF_W'(MAX_STEP);

  logic                     valid_q, valid_d;
  pwm_set_t                 data_q, data_d;
  logic signed [DIFF_W-1:0] diff_c, step_c;

  // Clamp the requested change and apply it only on an input strobe.
  always_comb begin
    diff_c  = DIFF_W'(target) - DIFF_W'(data_q);
    step_c  = diff_c;
    data_d  = data_q;
    valid_d = in_valid;
    if (diff_c > STEP_POS) begin
      step_c = STEP_POS;
    end else if (diff_c < -STEP_POS) begin
      step_c = -STEP_POS;
    end
    if (in_valid) begin
      data_d = data_q + PWM_W'(step_c);
    end
  end

  // Output register; reset drops any in-flight strobe and zeroes the drive.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/accel_tilt_filter.sv
// Tilt sample conditioner: moving average -> scale/saturate -> deadband -> slew limit.
module accel_tilt_filter
  import accel_filter_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned LOG2_DEPTH = 3,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned DEADBAND   = 4,
  parameter int unsigned MAX_STEP   = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  accel_tilt_filter_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;

  // S1 state: window, running sum, pointer, fill count
  logic signed [DATA_W-1:0] win_q [DEPTH];
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [LOG2_DEPTH-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     primed_q, primed_d;
  logic                     s1_valid_q, s1_valid_d;

  // S2 state: saturated, deadbanded target
  logic signed [SUM_W-1:0]  avg_c, scaled_c;
  pwm_set_t                 sat_c;
  pwm_set_t                 target_q, target_d;
  logic                     s2_valid_q;
  logic                     in_deadband_c;

  // Running-sum update and fill tracking; only a full window feeds the pipe.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (bus.sample_valid) begin
      sum_d = sum_q + SUM_W'(bus.sample_data) - SUM_W'(win_q[wr_ptr_q]);
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    primed_d   = (cnt_d == CNT_W'(DEPTH));
    s1_valid_d = bus.sample_valid && primed_d;
  end

  // S1 registers: window buffer, sum, pointer, count, primed flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      sum_q      <= sum_d;
      if (bus.sample_valid) begin
        win_q[wr_ptr_q] <= bus.sample_data;
        wr_ptr_q        <= wr_ptr_q + LOG2_DEPTH'(1);
      end
    end
  end

  // Average, scale to PWM range, saturate, then suppress small tilts.
  always_comb begin
    avg_c         = sum_q >>> LOG2_DEPTH;
    scaled_c      = avg_c >>> SHIFT;
    sat_c         = sat_pwm(32'(scaled_c));
    in_deadband_c = (32'(sat_c) <= $signed(32'(DEADBAND))) &&
                    (32'(sat_c) >= -$signed(32'(DEADBAND)));
    target_d      = target_q;
    if (s1_valid_q) begin
      target_d = in_deadband_c ? '0 : sat_c;
    end
  end

  // S2 registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      target_q   <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      target_q   <= target_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  slew_limiter #(
    .MAX_STEP (MAX_STEP)
  ) u_slew (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_valid  (s2_valid_q),
    .target    (target_q),
    .out_valid (bus.filt_valid),
    .out_data  (bus.filt_data)
  );

  assign bus.filt_primed = primed_q;

endmodule
